ahbl_regfile: RTL and testbench

- Parametrised AHB-Lite slave register file: NUM_REGS read/write 32-bit control registers plus one read-only ID word.
- Supports byte, halfword and word writes, and programmable data-phase wait states.
- Sits on the AHB-Lite bus as a generic peripheral control/status block; register contents are exported as a flat bus to downstream logic.

---
 rtl/ahbl_regfile.sv | 215 +++++++++++++++++++++
 tb/tb_ahbl_regfile.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ahbl_regfile.sv
// ---------------------------------------------------------------------------
// ahbl_regfile
//   AHB-Lite slave register file: NUM_REGS read/write 32-bit control
//   registers followed by one read-only ID word at byte offset NUM_REGS*4.
//   Byte/halfword/word writes and a fixed number of data-phase wait
//   states per accepted transfer.
//
//   Optional build macro: AHBL_REGFILE_ERR_EN
//     defined   - out-of-range accesses and writes to the ID word receive
//                 the two-cycle AHB ERROR response (no register change).
//     undefined - HRESP is 0; such accesses complete OKAY, writes are
//                 dropped and reads return 0.
//
//   Ports
//     HCLK, HRESETn           clock, asynchronous active-low reset
//     HADDR, HTRANS, HREADY,  AHB-Lite address-phase inputs
//     HSIZE, HWRITE, HSEL
//     HWDATA                  write data (data phase)
//     HREADYOUT, HRESP        slave ready / error response
//     HRDATA                  read data (0 outside read data phases)
//     regs_out                register i at bits [32*i+31:32*i]
//     reg_wr_pulse            bit i high the cycle after register i is written
// ---------------------------------------------------------------------------
module ahbl_regfile #(
   parameter int          NUM_REGS    = 4,
   parameter logic [31:0] ID          = 32'hABCD_EF00,
   parameter logic [31:0] RESET_VAL   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic                     HCLK,
   input  logic                     HRESETn,
   input  logic [31:0]              HADDR,
   input  logic [1:0]               HTRANS,
   input  logic                     HREADY,
   input  logic [2:0]               HSIZE,
   input  logic                     HWRITE,
   input  logic                     HSEL,
   input  logic [31:0]              HWDATA,
   output logic                     HREADYOUT,
   output logic                     HRESP,
   output logic [31:0]              HRDATA,
   output logic [NUM_REGS*32-1:0]   regs_out,
   output logic [NUM_REGS-1:0]      reg_wr_pulse
);

   localparam int IDX_W = ($clog2(NUM_REGS + 1) > 1) ? $clog2(NUM_REGS + 1) : 1;
   localparam logic [IDX_W-1:0] NREG_IDX  = IDX_W'(NUM_REGS);
   localparam logic [3:0]       WAIT_INIT = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
`ifdef AHBL_REGFILE_ERR_EN
      , S_ERR1,
      S_ERR2
`endif
   } state_t;

   state_t            r_state, w_state_nxt, w_first_state, w_done_state;
   logic [3:0]        r_cnt, w_cnt_nxt;
   logic [31:0]       r_haddr;
   logic [2:0]        r_hsize;
   logic              r_hwrite;
   logic [31:0]       r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_pulse;

   logic [IDX_W-1:0]  w_idx;
   logic              w_upper_zero, w_in_range, w_is_id;
   logic              w_start, w_commit;
   logic [3:0]        w_lanes;
   logic              w_unused;

   // Byte-lane enables for a write of the given size at the given offset.
   function automatic logic [3:0] f_lanes(input logic [2:0] sz, input logic [1:0] a);
      case (sz)
         3'd0:    return 4'b0001 << a;
         3'd1:    return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

`ifdef AHBL_REGFILE_ERR_EN
   logic r_bad;

   // True for accesses that must be answered with ERROR: anything past the
   // ID word, or a write to the ID word itself.
   function automatic logic f_bad(input logic [31:0] a, input logic wr);
      logic             up_zero;
      logic [IDX_W-1:0] idx;
      up_zero = (a[31:IDX_W+2] == '0);
      idx     = a[IDX_W+1:2];
      return !(up_zero && ((idx < NREG_IDX) || ((idx == NREG_IDX) && !wr)));
   endfunction

   assign w_first_state = f_bad(HADDR, HWRITE) ? S_ERR1 : S_DONE;
   assign w_done_state  = r_bad ? S_ERR1 : S_DONE;
`else
   assign w_first_state = S_DONE;
   assign w_done_state  = S_DONE;
`endif

   assign w_unused = HTRANS[0];
   assign w_start  = HREADY & HSEL & HTRANS[1];

   // Address bits above the index must be zero so that high addresses do
   // not alias onto the register bank.
   assign w_idx        = r_haddr[IDX_W+1:2];
   assign w_upper_zero = (r_haddr[31:IDX_W+2] == '0);
   assign w_in_range   = w_upper_zero && (w_idx < NREG_IDX);
   assign w_is_id      = w_upper_zero && (w_idx == NREG_IDX);
   assign w_lanes      = f_lanes(r_hsize, r_haddr[1:0]);
   assign w_commit     = (r_state == S_DONE) && r_hwrite && w_in_range;

   // Address phase capture
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_haddr  <= '0;
         r_hsize  <= '0;
         r_hwrite <= 1'b0;
`ifdef AHBL_REGFILE_ERR_EN
         r_bad    <= 1'b0;
`endif
      end else if (HREADY) begin
         r_haddr  <= HADDR;
         r_hsize  <= HSIZE;
         r_hwrite <= HWRITE;
`ifdef AHBL_REGFILE_ERR_EN
         r_bad    <= f_bad(HADDR, HWRITE);
`endif
      end
   end

   // Data phase FSM
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      HREADYOUT   = 1'b1;
      HRESP       = 1'b0;
      case (r_state)
         S_WAIT: begin
            HREADYOUT = 1'b0;
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) w_state_nxt = w_done_state;
         end
`ifdef AHBL_REGFILE_ERR_EN
         S_ERR1: begin
            HREADYOUT   = 1'b0;
            HRESP       = 1'b1;
            w_state_nxt = S_ERR2;
         end
`endif
         default: begin
            // IDLE, DONE and the final ERROR cycle all accept a new address.
`ifdef AHBL_REGFILE_ERR_EN
            if (r_state == S_ERR2) HRESP = 1'b1;
`endif
            w_state_nxt = S_IDLE;
            if (w_start) begin
               if (WAIT_STATES > 0) begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = WAIT_INIT;
               end else begin
                  w_state_nxt = w_first_state;
               end
            end
         end
      endcase
   end

   // Register bank and write pulses
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
         r_pulse <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_pulse[i] <= w_commit && (w_idx == IDX_W'(i));
            if (w_commit && (w_idx == IDX_W'(i))) begin
               for (int b = 0; b < 4; b++) begin
                  if (w_lanes[b]) r_regs[i][8*b +: 8] <= HWDATA[8*b +: 8];
               end
            end
         end
      end
   end

   // Read mux: live only during a completing read data phase.
   always_comb begin
      HRDATA = '0;
      if ((r_state == S_DONE) && !r_hwrite) begin
         if (w_is_id) HRDATA = ID;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_in_range && (w_idx == IDX_W'(i))) HRDATA = r_regs[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) regs_out[32*i +: 32] = r_regs[i];
   end

   assign reg_wr_pulse = r_pulse;

endmodule

// File: tb/tb_ahbl_regfile.sv
// ---------------------------------------------------------------------------
// tb_ahbl_regfile
//   Directed bench for ahbl_regfile. Instance u_a has no wait states,
//   instance u_b has three; a select bit routes the shared bus stimulus to
//   one of them, and each slave's HREADY is its own HREADYOUT.
// ---------------------------------------------------------------------------
module tb_ahbl_regfile;

`ifdef AHBL_REGFILE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic         HCLK = 1'b0;
   logic         HRESETn;
   logic [31:0]  HADDR;
   logic [1:0]   HTRANS;
   logic [2:0]   HSIZE;
   logic         HWRITE;
   logic         HSEL;
   logic [31:0]  HWDATA;
   bit           sel;

   logic         ro_a, rsp_a, ro_b, rsp_b;
   logic [31:0]  rd_a, rd_b;
   logic [127:0] regs_a, regs_b;
   logic [3:0]   pulse_a, pulse_b;

   logic         w_hready, w_hresp;
   logic [31:0]  w_hrdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 HCLK = ~HCLK;

   assign w_hready = sel ? ro_b  : ro_a;
   assign w_hresp  = sel ? rsp_b : rsp_a;
   assign w_hrdata = sel ? rd_b  : rd_a;

   ahbl_regfile #(.NUM_REGS(4), .WAIT_STATES(0)) u_a (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
      .HREADY(ro_a), .HSIZE(HSIZE), .HWRITE(HWRITE), .HSEL(HSEL & ~sel),
      .HWDATA(HWDATA), .HREADYOUT(ro_a), .HRESP(rsp_a), .HRDATA(rd_a),
      .regs_out(regs_a), .reg_wr_pulse(pulse_a)
   );

   ahbl_regfile #(.NUM_REGS(4), .WAIT_STATES(3)) u_b (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
      .HREADY(ro_b), .HSIZE(HSIZE), .HWRITE(HWRITE), .HSEL(HSEL & sel),
      .HWDATA(HWDATA), .HREADYOUT(ro_b), .HRESP(rsp_b), .HRDATA(rd_b),
      .regs_out(regs_b), .reg_wr_pulse(pulse_b)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Single non-pipelined transfer; starts and ends just after a rising edge.
   task automatic xfer(input bit s, input logic [31:0] a, input bit wr,
                       input logic [2:0] sz, input logic [31:0] wd,
                       output logic [31:0] rd, output bit rsp, output int nw);
      nw  = 0;
      rd  = '0;
      rsp = 1'b0;
      sel = s;  HSEL = 1'b1;  HTRANS = 2'b10;
      HADDR = a;  HWRITE = wr;  HSIZE = sz;
      @(posedge HCLK); #1;
      HSEL = 1'b0;  HTRANS = 2'b00;  HWDATA = wd;
      for (int k = 0; k < 40; k++) begin
         @(negedge HCLK);
         if (w_hready) begin
            rd  = w_hrdata;
            rsp = w_hresp;
            @(posedge HCLK); #1;
            return;
         end
         nw++;
         @(posedge HCLK); #1;
      end
      check("xfer_timeout", 1'b1, 1'b0);
   endtask

   logic [31:0] rd;
   bit          rsp;
   int          nw;

   initial begin
      HRESETn = 1'b0;  HADDR = '0;  HTRANS = 2'b00;  HSIZE = 3'd2;
      HWRITE = 1'b0;  HSEL = 1'b0;  HWDATA = '0;  sel = 1'b0;
      repeat (2) @(posedge HCLK);
      #1;
      check("rst_regs",   regs_a, 128'h0);
      check("rst_ready",  ro_a,   1'b1);
      check("rst_resp",   rsp_a,  1'b0);
      check("rst_rdata",  rd_a,   32'h0);
      HRESETn = 1'b1;
      @(posedge HCLK); #1;

      // Word write to 0x08 immediately followed by a read of 0x08.
      sel = 1'b0;  HSEL = 1'b1;  HTRANS = 2'b10;
      HADDR = 32'h08;  HWRITE = 1'b1;  HSIZE = 3'd2;
      @(posedge HCLK); #1;
      HWRITE = 1'b0;  HWDATA = 32'h1234_5678;
      @(posedge HCLK); #1;
      HSEL = 1'b0;  HTRANS = 2'b00;
      @(negedge HCLK);
      check("b2b_pulse",  pulse_a,         4'b0100);
      check("b2b_reg2",   regs_a[95:64],   32'h1234_5678);
      check("b2b_rdata",  rd_a,            32'h1234_5678);
      @(posedge HCLK); #1;
      check("b2b_pulse_1cyc", pulse_a, 4'b0000);

      // Byte and halfword lane masking over an all-ones register.
      xfer(1'b0, 32'h00, 1'b1, 3'd2, 32'hFFFF_FFFF, rd, rsp, nw);
      check("w0_full",   regs_a[31:0], 32'hFFFF_FFFF);
      xfer(1'b0, 32'h01, 1'b1, 3'd0, 32'h0000_AB00, rd, rsp, nw);
      check("byte_wr",   regs_a[31:0], 32'hFFFF_ABFF);
      check("byte_pulse", pulse_a,     4'b0001);
      xfer(1'b0, 32'h02, 1'b1, 3'd1, 32'hBEEF_0000, rd, rsp, nw);
      check("half_wr",   regs_a[31:0], 32'hBEEF_ABFF);
      xfer(1'b0, 32'h00, 1'b0, 3'd0, 32'h0, rd, rsp, nw);
      check("rd_bytesize_full_word", rd, 32'hBEEF_ABFF);

      // ID word: readable, writes dropped.
      xfer(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, rd, rsp, nw);
      check("id_rd",      rd,  32'hABCD_EF00);
      check("id_rd_resp", rsp, 1'b0);
      xfer(1'b0, 32'h10, 1'b1, 3'd2, 32'h5555_5555, rd, rsp, nw);
      check("id_wr_pulse", pulse_a, 4'b0000);
      check("id_wr_resp",  rsp,     ERR_EN);
      check("id_wr_waits", nw,      32'(ERR_EN));
      check("id_wr_regs",  regs_a,  {32'h0, 32'h1234_5678, 32'h0, 32'hBEEF_ABFF});
      xfer(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, rd, rsp, nw);
      check("id_after_wr", rd, 32'hABCD_EF00);

      // Out-of-range index.
      xfer(1'b0, 32'h14, 1'b0, 3'd2, 32'h0, rd, rsp, nw);
      check("oor_rd",      rd,  32'h0);
      check("oor_rd_resp", rsp, ERR_EN);
      xfer(1'b0, 32'h14, 1'b1, 3'd2, 32'hDEAD_BEEF, rd, rsp, nw);
      check("oor_wr_pulse", pulse_a, 4'b0000);
      check("oor_wr_regs",  regs_a,  {32'h0, 32'h1234_5678, 32'h0, 32'hBEEF_ABFF});

      // Three wait states per transfer on u_b.
      xfer(1'b1, 32'h04, 1'b1, 3'd2, 32'hCAFE_0001, rd, rsp, nw);
      check("ws_wr_waits", nw,             32'd3);
      check("ws_wr_reg1",  regs_b[63:32],  32'hCAFE_0001);
      check("ws_wr_pulse", pulse_b,        4'b0010);
      xfer(1'b1, 32'h04, 1'b0, 3'd2, 32'h0, rd, rsp, nw);
      check("ws_rd_waits", nw, 32'd3);
      check("ws_rd_data",  rd, 32'hCAFE_0001);
      sel = 1'b1;  HSEL = 1'b1;  HTRANS = 2'b00;  HADDR = 32'h04;
      @(posedge HCLK); #1;
      HSEL = 1'b0;
      @(negedge HCLK);
      check("ws_idle_ready", ro_b, 1'b1);
      @(posedge HCLK); #1;

      // Reset in the middle of a waited write aborts it.
      sel = 1'b1;  HSEL = 1'b1;  HTRANS = 2'b10;
      HADDR = 32'h0C;  HWRITE = 1'b1;  HSIZE = 3'd2;
      @(posedge HCLK); #1;
      HSEL = 1'b0;  HTRANS = 2'b00;  HWDATA = 32'h55AA_55AA;
      @(posedge HCLK); #1;
      check("mid_wait_busy", ro_b, 1'b0);
      HRESETn = 1'b0;
      #1;
      check("rst_mid_ready", ro_b,           1'b1);
      check("rst_mid_reg3",  regs_b[127:96], 32'h0);
      check("rst_mid_reg1",  regs_b[63:32],  32'h0);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      repeat (4) @(posedge HCLK);
      #1;
      check("rst_mid_no_late_wr", regs_b[127:96], 32'h0);
      check("rst_mid_no_pulse",   pulse_b,        4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
